// File: rtl/lock_pkg.sv
// Shared types and defaults for the digital lock and its key front-end.
// The lock's own state type is expected to move here as well.
package lock_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage : lock_pkg

// File: rtl/key_debounce.sv
// One push-button channel: synchronizer, debounce FSM with stability counter,
// registered debounced level and a press strobe on the accepting edge.
module key_debounce
   import lock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic press_evt
);

   localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync;
   key_state_t             r_state;
   logic [CW-1:0]          r_cnt;
   logic                   r_level;
   logic                   w_cnt_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
      end
   end

   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign w_cnt_done = (r_cnt == CNT_MAX);

   // The counter only advances while the sampled level stays opposite to the
   // debounced level, and is capped by the compare, so it cannot wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= RELEASED;
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else begin
         case (r_state)
            RELEASED: begin
               if (w_sync) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= CNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!w_sync) begin
                  r_state <= RELEASED;
                  r_cnt   <= '0;
               end else if (w_cnt_done) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
                  r_level <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!w_sync) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= CNT_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (w_sync) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
               end else if (w_cnt_done) begin
                  r_state <= RELEASED;
                  r_cnt   <= '0;
                  r_level <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= RELEASED;
               r_cnt   <= '0;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   // Strobe is high in the cycle whose edge accepts the press; the consumer
   // registers it so the pulse lines up with the level rising.
   assign press_evt = (r_state == PRESS_WAIT) && w_sync && w_cnt_done;
   assign level     = r_level;

endmodule : key_debounce

// File: rtl/lock_key_conditioner.sv
// Two debounced key channels feeding a registered same-cycle arbiter that
// produces the single-cycle x/y pulses for the lock (Y wins a tie).
module lock_key_conditioner
   import lock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_x_raw,
   input  logic btn_y_raw,
   output logic x_pulse,
   output logic y_pulse,
   output logic x_level,
   output logic y_level
);

   logic w_x_level;
   logic w_y_level;
   logic w_x_evt;
   logic w_y_evt;
   logic r_x_pulse;
   logic r_y_pulse;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_key_x (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_x_raw),
      .level     (w_x_level),
      .press_evt (w_x_evt)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_key_y (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_y_raw),
      .level     (w_y_level),
      .press_evt (w_y_evt)
   );

   // A coinciding X press is dropped rather than deferred, matching the lock.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x_pulse <= 1'b0;
         r_y_pulse <= 1'b0;
      end else begin
         r_x_pulse <= w_x_evt & ~w_y_evt;
         r_y_pulse <= w_y_evt;
      end
   end

   assign x_pulse = r_x_pulse;
   assign y_pulse = r_y_pulse;
   assign x_level = w_x_level;
   assign y_level = w_y_level;

endmodule : lock_key_conditioner

// File: tb/tb_lock_key_conditioner.sv
// Segment-table stimulus for lock_key_conditioner with a per-cycle scoreboard
// plus per-segment pulse counts, pulse positions and settled levels.
module tb_lock_key_conditioner;

   localparam int DEB = 4;
   localparam int SYN = 2;
   localparam int HW  = SYN + DEB;

   logic clk = 1'b0;
   logic rst_n;
   logic btn_x_raw;
   logic btn_y_raw;
   logic x_pulse;
   logic y_pulse;
   logic x_level;
   logic y_level;

   always #5 clk = ~clk;

   lock_key_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .SYNC_STAGES     (SYN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_x_raw (btn_x_raw),
      .btn_y_raw (btn_y_raw),
      .x_pulse   (x_pulse),
      .y_pulse   (y_pulse),
      .x_level   (x_level),
      .y_level   (y_level)
   );

   typedef struct {
      bit rst;
      bit x;
      bit y;
      int len;
      int exp_xp;
      int exp_yp;
      int first_x;
      int first_y;
      bit exp_xl;
      bit exp_yl;
   } seg_t;

   typedef struct packed {
      logic xp;
      logic yp;
      logic xl;
      logic yl;
   } obs_t;

   seg_t segs[$];
   obs_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: raw sample history; the debounced level flips when the last
   // DEB samples the FSM has seen (those SYN edges old) all disagree with it.
   logic [HW-1:0] m_hx;
   logic [HW-1:0] m_hy;
   logic          m_xl;
   logic          m_yl;
   logic          m_xr;
   logic          m_yr;
   obs_t          ex;
   obs_t          act;

   task automatic add_seg(input bit rst, input bit x, input bit y, input int len,
                          input int exp_xp, input int exp_yp, input int first_x,
                          input int first_y, input bit exp_xl, input bit exp_yl);
      seg_t s;
      s.rst = rst; s.x = x; s.y = y; s.len = len;
      s.exp_xp = exp_xp; s.exp_yp = exp_yp;
      s.first_x = first_x; s.first_y = first_y;
      s.exp_xl = exp_xl; s.exp_yl = exp_yl;
      segs.push_back(s);
   endtask

   task automatic check(input string name, input int si, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s seg=%0d actual=%0d expected=%0d", name, si, actual, expected);
      end
   endtask

   initial begin
      //      rst x  y  len   xp yp fx  fy  xl yl
      add_seg(0, 0, 0, 3,    0, 0, -1, -1, 0, 0);  // reset
      add_seg(1, 1, 0, 20,   1, 0,  5, -1, 1, 0);  // clean X press
      add_seg(1, 0, 0, 10,   0, 0, -1, -1, 0, 0);
      add_seg(1, 0, 1, 3,    0, 0, -1, -1, 0, 0);  // Y bounce
      add_seg(1, 0, 0, 1,    0, 0, -1, -1, 0, 0);
      add_seg(1, 0, 1, 3,    0, 0, -1, -1, 0, 0);
      add_seg(1, 0, 0, 8,    0, 0, -1, -1, 0, 0);
      add_seg(1, 0, 1, 10,   0, 1, -1,  5, 0, 1);
      add_seg(1, 0, 0, 10,   0, 0, -1, -1, 0, 0);
      add_seg(1, 1, 0, 20,   1, 0,  5, -1, 1, 0);  // release and re-press
      add_seg(1, 0, 0, 10,   0, 0, -1, -1, 0, 0);
      add_seg(1, 1, 0, 20,   1, 0,  5, -1, 1, 0);
      add_seg(1, 0, 0, 10,   0, 0, -1, -1, 0, 0);
      add_seg(1, 1, 1, 15,   0, 1, -1,  5, 1, 1);  // simultaneous press
      add_seg(1, 0, 0, 10,   0, 0, -1, -1, 0, 0);
      add_seg(1, 1, 0, 3,    0, 0, -1, -1, 0, 0);  // reset mid-debounce
      add_seg(0, 1, 0, 2,    0, 0, -1, -1, 0, 0);
      add_seg(1, 1, 0, 15,   1, 0,  5, -1, 1, 0);
      add_seg(1, 0, 0, 10,   0, 0, -1, -1, 0, 0);
      add_seg(1, 1, 0, 1000, 1, 0,  5, -1, 1, 0);  // long hold + glitch
      add_seg(1, 0, 0, 2,    0, 0, -1, -1, 1, 0);
      add_seg(1, 1, 0, 20,   0, 0, -1, -1, 1, 0);
      add_seg(1, 0, 0, 10,   0, 0, -1, -1, 0, 0);

      m_hx = '0; m_hy = '0; m_xl = 1'b0; m_yl = 1'b0;

      for (int si = 0; si < segs.size(); si++) begin
         int nxp;
         int nyp;
         int fx;
         int fy;
         nxp = 0; nyp = 0; fx = -1; fy = -1;
         for (int e = 0; e < segs[si].len; e++) begin
            rst_n     = segs[si].rst;
            btn_x_raw = segs[si].x;
            btn_y_raw = segs[si].y;
            if (!segs[si].rst) begin
               m_hx = '0; m_hy = '0; m_xl = 1'b0; m_yl = 1'b0;
               ex = '0;
            end else begin
               m_hx = {m_hx[HW-2:0], segs[si].x};
               m_hy = {m_hy[HW-2:0], segs[si].y};
               m_xr = 1'b0;
               m_yr = 1'b0;
               if (!m_xl && (&m_hx[HW-1:SYN])) begin
                  m_xl = 1'b1; m_xr = 1'b1;
               end else if (m_xl && !(|m_hx[HW-1:SYN])) begin
                  m_xl = 1'b0;
               end
               if (!m_yl && (&m_hy[HW-1:SYN])) begin
                  m_yl = 1'b1; m_yr = 1'b1;
               end else if (m_yl && !(|m_hy[HW-1:SYN])) begin
                  m_yl = 1'b0;
               end
               ex.xp = m_xr & ~m_yr;
               ex.yp = m_yr;
               ex.xl = m_xl;
               ex.yl = m_yl;
            end
            sb_q.push_back(ex);
            @(posedge clk);
            #1;
            ex  = sb_q.pop_front();
            act = {x_pulse, y_pulse, x_level, y_level};
            n_checks++;
            if (act !== ex) begin
               n_fail++;
               $display("FAIL cycle seg=%0d edge=%0d {xp,yp,xl,yl} actual=%b expected=%b",
                        si, e, act, ex);
            end
            if (x_pulse === 1'b1) begin
               nxp++;
               if (fx < 0) fx = e;
            end
            if (y_pulse === 1'b1) begin
               nyp++;
               if (fy < 0) fy = e;
            end
         end
         check("x_pulse_count", si, nxp, segs[si].exp_xp);
         check("y_pulse_count", si, nyp, segs[si].exp_yp);
         check("x_pulse_edge",  si, fx,  segs[si].first_x);
         check("y_pulse_edge",  si, fy,  segs[si].first_y);
         check("x_level_end",   si, int'(x_level === 1'b1), int'(segs[si].exp_xl));
         check("y_level_end",   si, int'(y_level === 1'b1), int'(segs[si].exp_yl));
         $display("seg %0d rst=%0d x=%0d y=%0d len=%0d: x_pulses=%0d y_pulses=%0d x_level=%b y_level=%b",
                  si, segs[si].rst, segs[si].x, segs[si].y, segs[si].len, nxp, nyp, x_level, y_level);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_lock_key_conditioner
